// File: rtl/pixel_fifo_stage.sv
// Framed pixel FIFO: first-word fall-through queue with sop/eop frame checker.
// Define PIXEL_FIFO_WATERMARK_EN to add the max_level peak-occupancy output.
module pixel_fifo_stage #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 8,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     sop_in,
  input  logic                     eop_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [DATA_W-1:0]        data_out,
  output logic                     sop_out,
  output logic                     eop_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
`ifdef PIXEL_FIFO_WATERMARK_EN
  output logic [$clog2(DEPTH):0]   max_level,
`endif
  input  logic                     clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam int EW = DATA_W + 2;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [CW-1:0] NPIX = CW'(FRAME_PIXELS);
  localparam logic [CW-1:0] NPIX_M1 = CW'(FRAME_PIXELS - 1);
  localparam logic SOLO_ERR = (FRAME_PIXELS != 1);

  typedef enum logic {SEEK, FRAME} state_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic          err_q, err_d;
  logic          acc, push, pop, err_set, sat;
  logic [EW-1:0] head;

  // ready_out looks only at occupancy, never at ready_in
  assign ready_out = (level_q != FULL);
  assign valid_out = (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign data_out  = valid_out ? head[DATA_W-1:0] : '0;
  assign sop_out   = valid_out & head[DATA_W+1];
  assign eop_out   = valid_out & head[DATA_W];
  assign level     = level_q;
  assign frame_err = err_q;

  assign acc = valid_in & ready_out;
  assign pop = valid_out & ready_in;
  assign sat = (cnt_q == NPIX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    err_set = 1'b0;
    if (acc) begin
      unique case (state_q)
        SEEK: begin
          if (sop_in) begin
            push    = 1'b1;
            cnt_d   = CW'(1);
            state_d = eop_in ? SEEK : FRAME;
            err_set = eop_in & SOLO_ERR;
          end
        end
        FRAME: begin
          push = 1'b1;
          if (sop_in) begin
            cnt_d   = CW'(1);
            err_set = 1'b1;
            state_d = eop_in ? SEEK : FRAME;
          end else begin
            cnt_d = sat ? cnt_q : cnt_q + CW'(1);
            if (eop_in) begin
              state_d = SEEK;
              err_set = (cnt_q != NPIX_M1);
            end else begin
              err_set = sat;
            end
          end
        end
        default: state_d = SEEK;
      endcase
    end
    err_d    = err_set ? 1'b1 : (clear_err ? 1'b0 : err_q);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      state_q  <= SEEK;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      err_q    <= err_d;
    end
  end

  // storage needs no reset; outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sop_in, eop_in, data_in};
  end

`ifdef PIXEL_FIFO_WATERMARK_EN
  logic [LW-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (clear_err)             max_d = '0;
    else if (level_q > max_q)  max_d = level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) max_q <= '0;
    else        max_q <= max_d;
  end

  assign max_level = max_q;
`endif

endmodule

// File: tb/tb_pixel_fifo_stage.sv
// Directed bench for pixel_fifo_stage with DEPTH=4, FRAME_PIXELS=4.
// Each task drives one scenario and checks its own expectations inline.
module tb_pixel_fifo_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data_in;
  logic        sop_in, eop_in, valid_in;
  logic        ready_out;
  logic [11:0] data_out;
  logic        sop_out, eop_out, valid_out;
  logic        ready_in;
  logic [2:0]  level;
  logic        frame_err;
  logic        clear_err;
`ifdef PIXEL_FIFO_WATERMARK_EN
  logic [2:0]  max_level;
`endif

  int errors = 0;
  int checks = 0;
  logic [13:0] rx_q[$];
  logic [13:0] exp_q[$];
  bit done;

  pixel_fifo_stage #(.DATA_W(12), .DEPTH(4), .FRAME_PIXELS(4)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out),
    .valid_out(valid_out), .ready_in(ready_in),
    .level(level), .frame_err(frame_err),
`ifdef PIXEL_FIFO_WATERMARK_EN
    .max_level(max_level),
`endif
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset && valid_out && ready_in)
      rx_q.push_back({sop_out, eop_out, data_out});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [13:0] b);
    int n;
    {sop_in, eop_in, data_in} = b;
    valid_in = 1'b1;
    n = 0;
    while (!ready_out && n < 100) begin
      step();
      n++;
    end
    if (!ready_out) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: ready_out=%0b required 1", ready_out);
    end
    step();
    valid_in = 1'b0;
    sop_in = 1'b0;
    eop_in = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (level != 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL drain_timeout: level=%0d required 0", level);
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid_in = 0; sop_in = 0; eop_in = 0; data_in = '0;
    ready_in = 0; clear_err = 0;
    step();
    step();
    checks++;
    if ({valid_out, sop_out, eop_out} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags: got %b required 000",
               {valid_out, sop_out, eop_out});
    end
    checks++;
    if (level !== 3'd0 || data_out !== 12'h000) begin
      errors++;
      $display("FAIL rst_level_data: level=%0d data=%h required 0/000",
               level, data_out);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err: got %b required 0", frame_err);
    end
    reset = 1'b1;
    step();
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b required 1", ready_out);
    end
  endtask

  task automatic test_passthrough();
    logic [13:0] v[4];
    v[0] = {2'b10, 12'h18E};
    v[1] = {2'b00, 12'h14E};
    v[2] = {2'b00, 12'h2AA};
    v[3] = {2'b01, 12'hFFF};
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_beat(v[i]);
      checks++;
      if (valid_out !== 1'b1 || {sop_out, eop_out, data_out} !== v[i]) begin
        errors++;
        $display("FAIL pass_beat%0d: valid=%b beat=%h required 1/%h",
                 i, valid_out, {sop_out, eop_out, data_out}, v[i]);
      end
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL pass_end: valid=%b err=%b required 0/0",
               valid_out, frame_err);
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] v[8];
    int bad;
    v[0] = {2'b10, 12'hA01}; v[1] = {2'b00, 12'hA02};
    v[2] = {2'b00, 12'hA03}; v[3] = {2'b01, 12'hA04};
    v[4] = {2'b10, 12'hA05}; v[5] = {2'b00, 12'hA06};
    v[6] = {2'b00, 12'hA07}; v[7] = {2'b01, 12'hA08};
    rx_q.delete();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(v[i]);
    checks++;
    if (level !== 3'd4 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: level=%0d ready=%b required 4/0",
               level, ready_out);
    end
    {sop_in, eop_in, data_in} = v[4];
    valid_in = 1'b1;
    step();
    step();
    checks++;
    if (level !== 3'd4 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL bp_held: level=%0d rx=%0d required 4/0",
               level, rx_q.size());
    end
    ready_in = 1'b1;
    push_beat(v[4]);
    for (int i = 5; i < 8; i++) push_beat(v[i]);
    wait_empty();
    checks++;
    if (rx_q.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d required 8", rx_q.size());
    end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= rx_q.size() || rx_q[i] !== v[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_order: %0d wrong beats required 0", bad);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_err: got %b required 0", frame_err);
    end
  endtask

  task automatic test_seek_discard();
    rx_q.delete();
    ready_in = 1'b1;
    push_beat({2'b00, 12'h111});
    push_beat({2'b00, 12'h222});
    checks++;
    if (level !== 3'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL seek_drop: level=%0d valid=%b required 0/0",
               level, valid_out);
    end
    push_beat({2'b10, 12'h333});
    push_beat({2'b00, 12'h334});
    push_beat({2'b00, 12'h335});
    push_beat({2'b01, 12'h336});
    wait_empty();
    checks++;
    if (rx_q.size() != 4 || rx_q[0] !== {2'b10, 12'h333}) begin
      errors++;
      $display("FAIL seek_frame: size=%0d first=%h required 4/2333",
               rx_q.size(), rx_q.size() ? rx_q[0] : 14'h0);
    end
  endtask

  task automatic test_short_frame();
    ready_in = 1'b1;
    push_beat({2'b10, 12'h401});
    push_beat({2'b00, 12'h402});
    push_beat({2'b01, 12'h403});
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL short_set: got %b required 1", frame_err);
    end
    wait_empty();
    step();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL short_sticky: got %b required 1", frame_err);
    end
    pulse_clear();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL short_clear: got %b required 0", frame_err);
    end
  endtask

  task automatic test_err_cases();
    ready_in = 1'b1;
    push_beat({2'b11, 12'h501});
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL solo_beat: got %b required 1", frame_err);
    end
    pulse_clear();
    push_beat({2'b10, 12'h511});
    push_beat({2'b00, 12'h512});
    push_beat({2'b00, 12'h513});
    push_beat({2'b00, 12'h514});
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL long_at_limit: got %b required 0", frame_err);
    end
    push_beat({2'b00, 12'h515});
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL long_over: got %b required 1", frame_err);
    end
    pulse_clear();
    clear_err = 1'b1;
    push_beat({2'b01, 12'h516});
    clear_err = 1'b0;
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got %b required 1", frame_err);
    end
    pulse_clear();
    push_beat({2'b10, 12'h601});
    push_beat({2'b00, 12'h602});
    push_beat({2'b10, 12'h603});
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL sop_in_frame: got %b required 1", frame_err);
    end
    pulse_clear();
    push_beat({2'b00, 12'h604});
    push_beat({2'b00, 12'h605});
    push_beat({2'b01, 12'h606});
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_count: got %b required 0", frame_err);
    end
    wait_empty();
  endtask

  task automatic test_reset_midframe();
    ready_in = 1'b0;
    push_beat({2'b10, 12'h701});
    push_beat({2'b00, 12'h702});
    push_beat({2'b00, 12'h703});
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL mid_level: got %0d required 3", level);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL mid_async: valid=%b level=%0d required 0/0",
               valid_out, level);
    end
    step();
    reset = 1'b1;
    rx_q.delete();
    ready_in = 1'b1;
    push_beat({2'b10, 12'h711});
    push_beat({2'b00, 12'h712});
    push_beat({2'b00, 12'h713});
    push_beat({2'b01, 12'h714});
    wait_empty();
    checks++;
    if (rx_q.size() != 4 || rx_q[3] !== {2'b01, 12'h714} ||
        frame_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_new_frame: size=%0d err=%b required 4/0",
               rx_q.size(), frame_err);
    end
  endtask

  task automatic test_random();
    int bad;
    rx_q.delete();
    exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 10; f++)
          for (int i = 0; i < 4; i++) begin
            logic [13:0] b;
            b = {i == 0, i == 3, 12'(f * 16 + i + 'h800)};
            exp_q.push_back(b);
            push_beat(b);
          end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready_in = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    ready_in = 1'b1;
    wait_empty();
    checks++;
    if (rx_q.size() != 40) begin
      errors++;
      $display("FAIL rand_count: got %0d required 40", rx_q.size());
    end
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_order: %0d wrong beats required 0", bad);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rand_err: got %b required 0", frame_err);
    end
`ifdef PIXEL_FIFO_WATERMARK_EN
    checks++;
    if (max_level > 3'd4) begin
      errors++;
      $display("FAIL rand_max_level: got %0d required <=4", max_level);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_backpressure();
    test_seek_discard();
    test_short_frame();
    test_err_cases();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
